// File: rtl/median_frame_sequencer.sv
// Frame-level controller for the median filter: feeds one W*H frame from a
// valid/ready source into the filter, then waits (bounded) for frame_complete.
module median_frame_sequencer #(
  parameter int IMAGE_WIDTH   = 8,
  parameter int IMAGE_HEIGHT  = 8,
  parameter int PIXEL_WIDTH   = 8,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [CNT_W-1:0]       out_count,
  input  logic                   src_valid,
  input  logic [PIXEL_WIDTH-1:0] src_data,
  output logic                   src_ready,
  output logic                   flt_valid,
  output logic [PIXEL_WIDTH-1:0] flt_data,
  input  logic                   flt_out_valid,
  input  logic                   flt_frame_complete
);

  localparam int N  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  // Handshake: a source pixel moves exactly in a cycle where src_valid and
  // src_ready are both high; src_ready never depends on src_valid.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       in_count_q, in_count_d;
  logic [CNT_W-1:0]       out_count_q, out_count_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   flt_valid_q, flt_valid_d;
  logic [PIXEL_WIDTH-1:0] flt_data_q, flt_data_d;
  logic                   xfer;

  always_comb begin
    state_d     = state_q;
    in_count_d  = in_count_q;
    out_count_d = out_count_q;
    timer_d     = timer_q;
    src_ready   = (state_q == S_FEED) && !abort;
    xfer        = src_valid && src_ready;
    flt_valid_d = xfer;
    flt_data_d  = xfer ? src_data : flt_data_q;
    busy        = (state_q == S_FEED) || (state_q == S_DRAIN);
    done        = (state_q == S_DONE);
    error       = (state_q == S_ERROR);

    if (busy && flt_out_valid && (out_count_q != '1))
      out_count_d = out_count_q + CNT_W'(1);

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d     = S_FEED;
          in_count_d  = '0;
          out_count_d = '0;
        end
      end
      S_FEED: begin
        if (xfer) in_count_d = in_count_q + CNT_W'(1);
        // A completion before the whole frame was fed means the filter lost sync.
        if (flt_frame_complete) begin
          state_d = S_ERROR;
        end else if (xfer && (in_count_q == CNT_W'(N - 1))) begin
          state_d = S_DRAIN;
          timer_d = '0;
        end
      end
      S_DRAIN: begin
        timer_d = timer_q + TW'(1);
        if (flt_frame_complete)
          state_d = S_DONE;
        else if (timer_q == TW'(DRAIN_TIMEOUT - 1))
          state_d = S_ERROR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a coincident start, and keeps counts.
    if (abort) begin
      state_d     = S_IDLE;
      in_count_d  = in_count_q;
      out_count_d = out_count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_count_q  <= '0;
      out_count_q <= '0;
      timer_q     <= '0;
      flt_valid_q <= 1'b0;
      flt_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
      timer_q     <= timer_d;
      flt_valid_q <= flt_valid_d;
      flt_data_q  <= flt_data_d;
    end
  end

  assign out_count = out_count_q;
  assign flt_valid = flt_valid_q;
  assign flt_data  = flt_data_q;

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Bench for median_frame_sequencer: a vector table for short control
// sequences plus randomized full frames checked against a frame-level model.
module tb_median_frame_sequencer;

  localparam int N  = 64;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, src_valid, flt_out_valid, flt_frame_complete;
  logic [7:0]  src_data;
  logic        busy, done, error, src_ready, flt_valid;
  logic [7:0]  flt_data;
  logic [15:0] out_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  median_frame_sequencer #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .PIXEL_WIDTH(8),
    .DRAIN_TIMEOUT(TO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error), .out_count(out_count),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .flt_valid(flt_valid), .flt_data(flt_data),
    .flt_out_valid(flt_out_valid), .flt_frame_complete(flt_frame_complete)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; src_valid = 0; src_data = 0;
    flt_out_valid = 0; flt_frame_complete = 0;
  endtask

  // One frame from IDLE/ERROR. fc_after: drain cycle index at which
  // frame_complete is raised (-1 = never, expect timeout).
  task automatic run_frame(input int pct, input int fc_after, input bit noisy_start);
    int accepted = 0;
    int exp_out  = 0;
    int cyc      = 0;
    bit prev_x   = 0;
    bit fc;
    exp_q.delete();
    idle_inputs();
    start = 1;
    tick();
    start = 0;
    while (accepted < N && cyc < 4000) begin
      src_valid     = ($urandom_range(99) < pct);
      src_data      = 8'($urandom);
      flt_out_valid = $urandom_range(1);
      start         = noisy_start ? $urandom_range(1) : 1'b0;
      settle();
      chk("feed_busy", busy, 1);
      chk("feed_ready", src_ready, 1);
      chk("feed_error", error, 0);
      chk("feed_flt_valid", flt_valid, prev_x);
      if (prev_x) chk("feed_flt_data", flt_data, exp_q.pop_front());
      if (src_valid) begin
        exp_q.push_back(src_data);
        accepted++;
      end
      prev_x = src_valid;
      if (flt_out_valid) exp_out++;
      tick();
      cyc++;
    end
    if (accepted < N) chk("feed_budget", accepted, N);
    fc = 0;
    for (int d = 0; d < TO; d++) begin
      src_valid          = $urandom_range(1);
      src_data           = 8'($urandom);
      flt_out_valid      = $urandom_range(1);
      start              = noisy_start ? $urandom_range(1) : 1'b0;
      fc                 = (d == fc_after);
      flt_frame_complete = fc;
      settle();
      chk("drain_busy", busy, 1);
      chk("drain_ready", src_ready, 0);
      chk("drain_error", error, 0);
      chk("drain_done", done, 0);
      chk("drain_flt_valid", flt_valid, (d == 0) ? prev_x : 1'b0);
      if (d == 0 && prev_x) chk("drain_flt_data", flt_data, exp_q.pop_front());
      if (flt_out_valid) exp_out++;
      tick();
      if (fc) break;
    end
    idle_inputs();
    flt_out_valid = 1;
    start         = fc;
    settle();
    chk("end_busy", busy, 0);
    chk("end_done", done, fc);
    chk("end_error", error, !fc);
    chk("end_out_count", out_count, exp_out);
    tick();
    start = 0;
    settle();
    chk("after_done_low", done, 0);
    chk("after_busy", busy, 0);
    chk("after_out_count_held", out_count, exp_out);
    idle_inputs();
  endtask

  typedef struct {
    logic st, ab, sv, fc;
    logic e_busy, e_rdy, e_fv, e_done, e_err;
  } vec_t;
  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1,0,0,0, 0,0,0,0,0};
    tbl[1]  = '{0,0,1,0, 1,1,0,0,0};
    tbl[2]  = '{0,0,0,0, 1,1,1,0,0};
    tbl[3]  = '{0,1,1,0, 1,0,0,0,0};
    tbl[4]  = '{0,0,1,0, 0,0,0,0,0};
    tbl[5]  = '{1,1,0,0, 0,0,0,0,0};
    tbl[6]  = '{0,0,0,0, 0,0,0,0,0};
    tbl[7]  = '{1,0,0,0, 0,0,0,0,0};
    tbl[8]  = '{0,0,1,0, 1,1,0,0,0};
    tbl[9]  = '{0,0,1,1, 1,1,1,0,0};
    tbl[10] = '{0,0,0,0, 0,0,1,0,1};
    tbl[11] = '{0,0,0,0, 0,0,0,0,1};
    tbl[12] = '{1,0,0,0, 0,0,0,0,1};
    tbl[13] = '{0,0,0,0, 1,1,0,0,0};
    tbl[14] = '{0,1,0,0, 1,0,0,0,0};
    tbl[15] = '{0,0,0,0, 0,0,0,0,0};

    idle_inputs();
    rst = 1;
    tick();
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_flt_valid", flt_valid, 0);
    chk("rst_flt_data", flt_data, 0);
    chk("rst_out_count", out_count, 0);
    tick();
    rst = 0;
    tick();

    // Short control sequences: abort, abort-beats-start, premature completion.
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; src_valid = tbl[i].sv;
      flt_frame_complete = tbl[i].fc; src_data = 8'($urandom);
      settle();
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_ready", i), src_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_flt_valid", i), flt_valid, tbl[i].e_fv);
      chk($sformatf("vec%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("vec%0d_error", i), error, tbl[i].e_err);
      tick();
    end
    idle_inputs();

    run_frame(100, 5, 0);    // nominal, valid held
    run_frame(50, 0, 1);     // backpressure + ignored starts, immediate completion
    run_frame(70, -1, 0);    // timeout -> error
    run_frame(100, 63, 0);   // restart from ERROR; completion on the last timeout cycle wins
    run_frame(30, 20, 1);

    // Abort together with start at pixel 30, then a full frame.
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 30; i++) begin
      src_valid = 1; src_data = 8'($urandom);
      settle();
      chk("abort_seq_ready", src_ready, 1);
      tick();
    end
    src_valid = 1; abort = 1; start = 1;
    settle();
    chk("abort_ready_low", src_ready, 0);
    tick();
    idle_inputs();
    settle();
    chk("abort_busy", busy, 0);
    chk("abort_flt_valid", flt_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    tick();
    settle();
    chk("abort_stays_idle", busy, 0);
    run_frame(100, 3, 0);

    // Asynchronous reset mid-FEED, between clock edges.
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 20; i++) begin
      src_valid = 1; src_data = 8'($urandom); flt_out_valid = 1;
      tick();
    end
    settle();
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", src_ready, 0);
    chk("arst_flt_valid", flt_valid, 0);
    chk("arst_flt_data", flt_data, 0);
    chk("arst_out_count", out_count, 0);
    chk("arst_error", error, 0);
    chk("arst_done", done, 0);
    #1;
    rst = 0;
    idle_inputs();
    tick();
    run_frame(60, 10, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
